// File: rtl/button_pkg.sv
// Shared definitions for button event decoding (decoder and setpoint controller).
package button_pkg;

    localparam int unsigned REPEAT_CNT_W = 8;
    localparam logic [REPEAT_CNT_W-1:0] REPEAT_CNT_MAX = '1;

    typedef enum logic [1:0] {
        LOCKOUT = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        REPEAT  = 2'd3
    } state_t;

    // Width able to hold values 0 .. max(a,b)-1 with one bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/short/long/auto-repeat pulses.
module button_event_decoder
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYC   = 100_000_000,
    parameter int unsigned REPEAT_CYC = 20_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    btn_level,
    output logic                    press_pulse,
    output logic                    release_pulse,
    output logic                    short_press,
    output logic                    long_press,
    output logic                    repeat_pulse,
    output logic                    held,
    output logic [REPEAT_CNT_W-1:0] repeat_count
);

    localparam int unsigned CNT_W = cnt_width(LONG_CYC, REPEAT_CYC);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;

    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [REPEAT_CNT_W-1:0] w_rc_nxt;
    logic                    w_press_nxt;
    logic                    w_release_nxt;
    logic                    w_short_nxt;
    logic                    w_long_nxt;
    logic                    w_repeat_nxt;
    logic                    w_held_nxt;

    // Next-state, counter and event decode; a release always beats a threshold hit.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rc_nxt      = repeat_count;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_short_nxt   = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;

        if (!en) begin
            w_state_nxt = LOCKOUT;
        end else begin
            case (r_state)
                LOCKOUT: begin
                    if (!btn_level) begin
                        w_state_nxt = IDLE;
                    end
                end
                IDLE: begin
                    if (btn_level) begin
                        w_state_nxt = PRESSED;
                        w_press_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_rc_nxt    = '0;
                    end
                end
                PRESSED: begin
                    if (!btn_level) begin
                        w_state_nxt   = IDLE;
                        w_release_nxt = 1'b1;
                        w_short_nxt   = 1'b1;
                    end else if (r_cnt == LONG_LAST) begin
                        w_state_nxt = REPEAT;
                        w_long_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!btn_level) begin
                        w_state_nxt   = IDLE;
                        w_release_nxt = 1'b1;
                    end else if (r_cnt == REPEAT_LAST) begin
                        w_repeat_nxt = 1'b1;
                        w_cnt_nxt    = '0;
                        if (repeat_count != REPEAT_CNT_MAX) begin
                            w_rc_nxt = repeat_count + REPEAT_CNT_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = LOCKOUT;
                end
            endcase
        end

        w_held_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == REPEAT);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= LOCKOUT;
            r_cnt         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            repeat_count  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            press_pulse   <= w_press_nxt;
            release_pulse <= w_release_nxt;
            short_press   <= w_short_nxt;
            long_press    <= w_long_nxt;
            repeat_pulse  <= w_repeat_nxt;
            held          <= w_held_nxt;
            repeat_count  <= w_rc_nxt;
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with short thresholds.
module tb_button_event_decoder;
    import button_pkg::*;

    localparam int unsigned LONG_CYC   = 20;
    localparam int unsigned REPEAT_CYC = 5;

    localparam logic [4:0] EV_PRESS = 5'b10000;
    localparam logic [4:0] EV_REL   = 5'b01000;
    localparam logic [4:0] EV_SHORT = 5'b00100;
    localparam logic [4:0] EV_LONG  = 5'b00010;
    localparam logic [4:0] EV_REP   = 5'b00001;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       short_press;
    logic       long_press;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] repeat_count;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [4:0] ev;
        int         rc;
    } exp_t;

    exp_t exp_q[$];

    button_event_decoder #(
        .LONG_CYC  (LONG_CYC),
        .REPEAT_CYC(REPEAT_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .repeat_count (repeat_count)
    );

    always #5 clk = ~clk;

    // Cycle index = number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        logic [4:0] ev;
        exp_t       e;
        ev = {press_pulse, release_pulse, short_press, long_press, repeat_pulse};
        if (ev != 5'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got ev=%b rc=%0d, required no event",
                         cyc, ev, repeat_count);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.ev != ev || e.rc != int'(repeat_count)) begin
                    errors++;
                    $display("FAIL event got cyc=%0d ev=%b rc=%0d, required cyc=%0d ev=%b rc=%0d",
                             cyc, ev, repeat_count, e.cyc, e.ev, e.rc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int c, input logic [4:0] ev, input int rc);
        exp_t e;
        e.cyc = c;
        e.ev  = ev;
        e.rc  = rc;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    function automatic int all_outs();
        return int'({press_pulse, release_pulse, short_press, long_press,
                     repeat_pulse, held, repeat_count});
    endfunction

    initial begin
        int p;
        int held_cnt;

        reset     = 1'b1;
        en        = 1'b1;
        btn_level = 1'b1;
        tick(3);
        chk("reset_outputs", all_outs(), 0);
        reset = 1'b0;

        // Button held through reset: lockout, no press.
        tick(10);
        chk("lockout_held", int'(held), 0);
        btn_level = 1'b0;
        tick(3);

        // 1: short 3-cycle press.
        p = cyc;
        btn_level = 1'b1;
        push_ev(p + 1, EV_PRESS, 0);
        push_ev(p + 4, EV_REL | EV_SHORT, 0);
        held_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (held) held_cnt++;
            if (i == 2) btn_level = 1'b0;
        end
        chk("short_held_cycles", held_cnt, 3);

        // 2: long hold, six repeats, release on the would-be seventh repeat.
        tick(2);
        p = cyc;
        btn_level = 1'b1;
        push_ev(p + 1, EV_PRESS, 0);
        push_ev(p + 21, EV_LONG, 0);
        for (int n = 1; n <= 6; n++) push_ev(p + 21 + 5 * n, EV_REP, n);
        push_ev(p + 56, EV_REL, 6);
        tick(55);
        chk("t2_repeat_count", int'(repeat_count), 6);
        chk("t2_held", int'(held), 1);
        btn_level = 1'b0;
        tick(3);
        chk("t2_held_after_release", int'(held), 0);

        // 3: release on the cycle the long threshold is reached.
        p = cyc;
        btn_level = 1'b1;
        push_ev(p + 1, EV_PRESS, 0);
        push_ev(p + 21, EV_REL | EV_SHORT, 0);
        tick(20);
        btn_level = 1'b0;
        tick(3);

        // 4: en dropped 10 cycles into REPEAT.
        p = cyc;
        btn_level = 1'b1;
        push_ev(p + 1, EV_PRESS, 0);
        push_ev(p + 21, EV_LONG, 0);
        push_ev(p + 26, EV_REP, 1);
        push_ev(p + 31, EV_REP, 2);
        tick(31);
        en = 1'b0;
        tick(1);
        chk("t4_held_after_en_low", int'(held), 0);
        chk("t4_repeat_count_hold", int'(repeat_count), 2);
        tick(10);
        en = 1'b1;
        tick(10);
        chk("t4_no_press_while_held", int'(held), 0);
        btn_level = 1'b0;
        tick(3);
        p = cyc;
        btn_level = 1'b1;
        push_ev(p + 1, EV_PRESS, 0);
        push_ev(p + 3, EV_REL | EV_SHORT, 0);
        tick(2);
        btn_level = 1'b0;
        tick(3);

        // 5: async reset between edges mid-PRESSED.
        p = cyc;
        btn_level = 1'b1;
        push_ev(p + 1, EV_PRESS, 0);
        tick(5);
        chk("t5_held_before_reset", int'(held), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_reset_outputs", all_outs(), 0);
        tick(2);
        reset = 1'b0;
        tick(10);
        chk("t5_no_resume", int'(held), 0);
        btn_level = 1'b0;
        tick(3);
        p = cyc;
        btn_level = 1'b1;
        push_ev(p + 1, EV_PRESS, 0);
        push_ev(p + 4, EV_REL | EV_SHORT, 0);
        tick(3);
        btn_level = 1'b0;
        tick(3);

        // 6: very long hold, repeat_count saturates while repeats continue.
        p = cyc;
        btn_level = 1'b1;
        push_ev(p + 1, EV_PRESS, 0);
        push_ev(p + 21, EV_LONG, 0);
        for (int n = 1; n <= 270; n++) push_ev(p + 21 + 5 * n, EV_REP, (n > 255) ? 255 : n);
        push_ev(p + 1374, EV_REL, 255);
        tick(1373);
        chk("t6_repeat_count_sat", int'(repeat_count), 255);
        btn_level = 1'b0;
        tick(4);

        chk("pending_expected_events", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
